// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and source ids for the port-2 writeback arbiter
package wb_pkg;

  typedef struct packed {
    logic [5:0]  dest;
    logic [31:0] data;
    logic [4:0]  rob;
    logic        cmp;
  } wb_entry_t;

  localparam logic SRC_LQ = 1'b0;
  localparam logic SRC_MS = 1'b1;

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - small per-producer FIFO with MSB-wrap full/empty detection
module wb_skid_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_push,
  input  T     i_push_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Extra pointer bit distinguishes full from empty; wraps modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/p2_writeback_arbiter.sv
// rtl/p2_writeback_arbiter.sv - arbitrates LQ and memsched writebacks onto the port-2 PRF write and completion bus
module p2_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic        flush_i,
  input  logic        lq_valid_i,
  output logic        lq_ready_o,
  input  logic [5:0]  lq_dest_i,
  input  logic [31:0] lq_data_i,
  input  logic [4:0]  lq_rob_i,
  input  logic        ms_valid_i,
  output logic        ms_ready_o,
  input  logic [5:0]  ms_dest_i,
  input  logic [31:0] ms_data_i,
  input  logic [4:0]  ms_rob_i,
  input  logic        ms_cmp_i,
  output logic        p2_we_o,
  output logic [5:0]  p2_dest_o,
  output logic [31:0] p2_data_o,
  output logic        cmp_valid_o,
  output logic [4:0]  cmp_rob_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t   w_lq_in, w_ms_in, w_lq_head, w_ms_head, w_head;
  logic        w_lq_full, w_lq_empty, w_ms_full, w_ms_empty;
  logic        w_grant_lq, w_grant_ms, w_any, w_src, w_starved;
  logic [SW-1:0] r_starve;
  logic        r_we, r_cmp;
  logic [5:0]  r_dest;
  logic [31:0] r_data;
  logic [4:0]  r_rob;

  assign w_lq_in    = '{dest: lq_dest_i, data: lq_data_i, rob: lq_rob_i, cmp: 1'b1};
  assign w_ms_in    = '{dest: ms_dest_i, data: ms_data_i, rob: ms_rob_i, cmp: ms_cmp_i};
  assign lq_ready_o = !w_lq_full;
  assign ms_ready_o = !w_ms_full;

  wb_skid_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_lq_fifo (
    .clk(cpu_clk_i), .rst_n(cpu_rst_ni), .i_flush(flush_i),
    .i_push(lq_valid_i), .i_push_data(w_lq_in), .i_pop(w_grant_lq),
    .o_head(w_lq_head), .o_full(w_lq_full), .o_empty(w_lq_empty)
  );

  wb_skid_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_ms_fifo (
    .clk(cpu_clk_i), .rst_n(cpu_rst_ni), .i_flush(flush_i),
    .i_push(ms_valid_i), .i_push_data(w_ms_in), .i_pop(w_grant_ms),
    .o_head(w_ms_head), .o_full(w_ms_full), .o_empty(w_ms_empty)
  );

  // LQ has priority unless memsched has been passed over STARVE_MAX times in a row.
  assign w_starved  = (r_starve == SW'(STARVE_MAX));
  assign w_grant_ms = !w_ms_empty && (w_lq_empty || w_starved);
  assign w_grant_lq = !w_lq_empty && !w_grant_ms;
  assign w_any      = w_grant_lq || w_grant_ms;
  assign w_src      = w_grant_ms ? SRC_MS : SRC_LQ;
  assign w_head     = w_grant_ms ? w_ms_head : w_lq_head;

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      r_starve <= '0;
    end else if (flush_i || w_ms_empty || w_grant_ms) begin
      r_starve <= '0;
    end else if (w_grant_lq && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      r_we   <= 1'b0;
      r_cmp  <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_rob  <= '0;
    end else if (flush_i) begin
      r_we   <= 1'b0;
      r_cmp  <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_rob  <= '0;
    end else begin
      r_we  <= w_any;
      r_cmp <= w_any && ((w_src == SRC_LQ) || w_head.cmp);
      if (w_any) begin
        r_dest <= w_head.dest;
        r_data <= w_head.data;
        r_rob  <= w_head.rob;
      end
    end
  end

  assign p2_we_o     = r_we;
  assign p2_dest_o   = r_dest;
  assign p2_data_o   = r_data;
  assign cmp_valid_o = r_cmp;
  assign cmp_rob_o   = r_rob;

endmodule

// File: tb/tb_p2_writeback_arbiter.sv
// tb/tb_p2_writeback_arbiter.sv - scoreboard bench for the port-2 writeback arbiter
module tb_p2_writeback_arbiter;
  import wb_pkg::*;

  logic        cpu_clk_i = 1'b0;
  logic        cpu_rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        lq_valid_i = 1'b0, ms_valid_i = 1'b0, ms_cmp_i = 1'b0;
  logic        lq_ready_o, ms_ready_o;
  logic [5:0]  lq_dest_i = '0, ms_dest_i = '0;
  logic [31:0] lq_data_i = '0, ms_data_i = '0;
  logic [4:0]  lq_rob_i = '0, ms_rob_i = '0;
  logic        p2_we_o, cmp_valid_o;
  logic [5:0]  p2_dest_o;
  logic [31:0] p2_data_o;
  logic [4:0]  cmp_rob_o;

  p2_writeback_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
    .cpu_clk_i(cpu_clk_i), .cpu_rst_ni(cpu_rst_ni), .flush_i(flush_i),
    .lq_valid_i(lq_valid_i), .lq_ready_o(lq_ready_o), .lq_dest_i(lq_dest_i),
    .lq_data_i(lq_data_i), .lq_rob_i(lq_rob_i),
    .ms_valid_i(ms_valid_i), .ms_ready_o(ms_ready_o), .ms_dest_i(ms_dest_i),
    .ms_data_i(ms_data_i), .ms_rob_i(ms_rob_i), .ms_cmp_i(ms_cmp_i),
    .p2_we_o(p2_we_o), .p2_dest_o(p2_dest_o), .p2_data_o(p2_data_o),
    .cmp_valid_o(cmp_valid_o), .cmp_rob_o(cmp_rob_o)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  typedef struct { bit src; int cyc; } log_t;

  wb_entry_t lq_q[$];
  wb_entry_t ms_q[$];
  log_t      wlog[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    check_eq("cmp_without_we", {63'd0, cmp_valid_o & ~p2_we_o}, 64'd0);
    if (p2_we_o) begin
      if (lq_q.size() > 0 && lq_q[0].dest == p2_dest_o && lq_q[0].data == p2_data_o
          && lq_q[0].rob == cmp_rob_o) begin
        check_eq("lq_cmp_valid", cmp_valid_o, 1);
        void'(lq_q.pop_front());
        wlog.push_back('{1'b0, cyc});
      end else if (ms_q.size() > 0 && ms_q[0].dest == p2_dest_o && ms_q[0].data == p2_data_o
                   && ms_q[0].rob == cmp_rob_o) begin
        check_eq("ms_cmp_valid", cmp_valid_o, ms_q[0].cmp);
        void'(ms_q.pop_front());
        wlog.push_back('{1'b1, cyc});
      end else if (lq_q.size() > 0) begin
        check_eq("unexpected_write_vs_lq_head", {p2_dest_o, p2_data_o, cmp_rob_o},
                 {lq_q[0].dest, lq_q[0].data, lq_q[0].rob});
      end else if (ms_q.size() > 0) begin
        check_eq("unexpected_write_vs_ms_head", {p2_dest_o, p2_data_o, cmp_rob_o},
                 {ms_q[0].dest, ms_q[0].data, ms_q[0].rob});
      end else begin
        check_eq("write_with_empty_scoreboard", p2_we_o, 0);
      end
    end
  endtask

  task automatic step();
    if (lq_valid_i && !lq_ready_o) check_eq("lq_valid_without_ready", 1, 0);
    if (ms_valid_i && !ms_ready_o) check_eq("ms_valid_without_ready", 1, 0);
    if (flush_i) begin
      lq_q.delete();
      ms_q.delete();
    end else begin
      if (lq_valid_i) lq_q.push_back('{dest: lq_dest_i, data: lq_data_i, rob: lq_rob_i, cmp: 1'b1});
      if (ms_valid_i) ms_q.push_back('{dest: ms_dest_i, data: ms_data_i, rob: ms_rob_i, cmp: ms_cmp_i});
    end
    @(negedge cpu_clk_i);
    cyc++;
    monitor();
    lq_valid_i = 1'b0;
    ms_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic lq_offer(input logic [5:0] d, input logic [31:0] x, input logic [4:0] r);
    if (lq_ready_o) begin
      lq_valid_i = 1'b1; lq_dest_i = d; lq_data_i = x; lq_rob_i = r;
    end
  endtask

  task automatic ms_offer(input logic [5:0] d, input logic [31:0] x, input logic [4:0] r, input logic c);
    if (ms_ready_o) begin
      ms_valid_i = 1'b1; ms_dest_i = d; ms_data_i = x; ms_rob_i = r; ms_cmp_i = c;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (lq_q.size() > 0 || ms_q.size() > 0); i++) step();
    check_eq("drain_lq_left", lq_q.size(), 0);
    check_eq("drain_ms_left", ms_q.size(), 0);
    repeat (3) step();
  endtask

  function automatic int log_cyc(input int idx);
    return (idx < wlog.size()) ? wlog[idx].cyc : -1;
  endfunction

  function automatic int log_src(input int idx);
    return (idx < wlog.size()) ? int'(wlog[idx].src) : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int base, k, ms_pos, ms_pushed;
    bit popped;

    repeat (2) @(negedge cpu_clk_i);
    check_eq("rst_we", p2_we_o, 0);
    check_eq("rst_cmp", cmp_valid_o, 0);
    check_eq("rst_payload", {p2_dest_o, p2_data_o, cmp_rob_o}, 0);
    cpu_rst_ni = 1'b1;
    @(negedge cpu_clk_i);
    check_eq("rst_lq_ready", lq_ready_o, 1);
    check_eq("rst_ms_ready", ms_ready_o, 1);

    // 1: lone LQ write, two-edge latency, single cycle
    base = wlog.size();
    lq_offer(6'd5, 32'hDEADBEEF, 5'd3);
    step();
    k = cyc;
    check_eq("t1_not_early", p2_we_o, 0);
    repeat (4) step();
    check_eq("t1_writes", wlog.size() - base, 1);
    check_eq("t1_latency_cyc", log_cyc(base), k + 1);

    // 2: simultaneous push, LQ first then MS
    base = wlog.size();
    lq_offer(6'd5, 32'hAAAA5555, 5'd1);
    ms_offer(6'd9, 32'h11, 5'd7, 1'b1);
    step();
    k = cyc;
    drain();
    check_eq("t2_writes", wlog.size() - base, 2);
    check_eq("t2_first_src", log_src(base), 0);
    check_eq("t2_first_cyc", log_cyc(base), k + 1);
    check_eq("t2_second_src", log_src(base + 1), 1);
    check_eq("t2_second_cyc", log_cyc(base + 1), k + 2);

    // 3: LQ streams, MS forced in on the 4th contended cycle
    base = wlog.size();
    for (int i = 0; i < 10; i++) begin
      lq_offer(6'(10 + i), 32'h300 + i, 5'(i));
      if (i == 0) ms_offer(6'd40, 32'h3333, 5'd20, 1'b1);
      step();
    end
    drain();
    ms_pos = -1;
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i].src && ms_pos < 0) ms_pos = i - base;
    check_eq("t3_ms_position", ms_pos, 3);
    check_eq("t3_lq_after_ms", log_src(base + 4), 0);

    // 4: MS full while LQ saturates; ready returns with the MS pop
    ms_pushed = 0;
    popped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lq_offer(6'(20 + i), 32'h400 + i, 5'(i));
      if (ms_pushed < 2 && ms_ready_o) begin
        ms_offer(6'(50 + ms_pushed), 32'h4440 + ms_pushed, 5'(24 + ms_pushed), 1'b1);
        ms_pushed++;
      end
      step();
      if (ms_pushed == 2 && !popped) begin
        if (wlog.size() > 0 && wlog[$].cyc == cyc && wlog[$].src) begin
          check_eq("t4_ready_after_pop", ms_ready_o, 1);
          popped = 1'b1;
        end else begin
          check_eq("t4_ready_while_full", ms_ready_o, 0);
        end
      end
    end
    check_eq("t4_pop_seen", popped, 1);
    drain();

    // 5: flush with queued work and a push in the flush cycle
    for (int i = 0; i < 3; i++) begin
      lq_offer(6'(30 + i), 32'h500 + i, 5'(i));
      ms_offer(6'(60 + i), 32'h5550 + i, 5'(10 + i), 1'b1);
      step();
    end
    check_eq("t5_ms_full_before_flush", ms_ready_o, 0);
    flush_i = 1'b1;
    lq_offer(6'd35, 32'h5FF, 5'd9);
    step();
    check_eq("t5_we_after_flush", p2_we_o, 0);
    check_eq("t5_cmp_after_flush", cmp_valid_o, 0);
    check_eq("t5_lq_ready", lq_ready_o, 1);
    check_eq("t5_ms_ready", ms_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_idle_we", p2_we_o, 0);
    end

    // 6: write-only MS entry, then async reset mid-stream
    base = wlog.size();
    ms_offer(6'd33, 32'h6666, 5'd12, 1'b0);
    step();
    drain();
    check_eq("t6_ms_nocmp_writes", wlog.size() - base, 1);

    lq_offer(6'd1, 32'h7777, 5'd2);
    ms_offer(6'd2, 32'h8888, 5'd4, 1'b1);
    step();
    lq_offer(6'd3, 32'h9999, 5'd6);
    step();
    check_eq("t6_active_before_reset", p2_we_o, 1);
    #2 cpu_rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_we", p2_we_o, 0);
    check_eq("t6_rst_cmp", cmp_valid_o, 0);
    check_eq("t6_rst_payload", {p2_dest_o, p2_data_o, cmp_rob_o}, 0);
    lq_q.delete();
    ms_q.delete();
    @(negedge cpu_clk_i);
    cpu_rst_ni = 1'b1;
    @(negedge cpu_clk_i);
    check_eq("t6_lq_ready", lq_ready_o, 1);
    check_eq("t6_ms_ready", ms_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_idle_we", p2_we_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
